// File: rtl/plane_ray_rob_pkg.sv
// Shared types for the plane-ray result collector: tags, status flags,
// per-slot state and the stored entry layout.
package plane_ray_rob_pkg;

    typedef logic [4:0] tag_t;
    typedef logic [4:0] status_t;

    localparam int unsigned RobDepth = 2**$bits(tag_t);

    typedef enum logic [1:0] {SLOT_FREE, SLOT_PEND, SLOT_DONE} slot_state_e;

    typedef struct packed {
        logic [31:0] result;
        status_t     status;
    } rob_entry_t;

endpackage

// File: rtl/plane_ray_rob.sv
// In-order result collector: tags are granted in order, FPU slices write
// results back out of order by tag, and results retire in allocation order.
module plane_ray_rob
    import plane_ray_rob_pkg::*;
#(
    parameter int unsigned DEPTH  = RobDepth,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    output tag_t              alloc_tag_o,
    input  logic              fma_valid_i,
    input  tag_t              fma_tag_i,
    input  logic [DATA_W-1:0] fma_result_i,
    input  status_t           fma_status_i,
    input  logic              div_valid_i,
    input  tag_t              div_tag_i,
    input  logic [DATA_W-1:0] div_result_i,
    input  status_t           div_status_i,
    input  logic              cmp_valid_i,
    input  tag_t              cmp_tag_i,
    input  logic [DATA_W-1:0] cmp_result_i,
    input  status_t           cmp_status_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output tag_t              out_tag_o,
    output logic [DATA_W-1:0] out_result_o,
    output status_t           out_status_o,
    output logic [5:0]        count_o,
    output logic              err_o
);

    slot_state_e       r_state  [DEPTH];
    logic [DATA_W-1:0] r_result [DEPTH];
    status_t           r_status [DEPTH];
    tag_t              r_head;
    tag_t              r_tail;
    logic [5:0]        r_count;
    logic              r_err;

    logic w_alloc;
    logic w_retire;
    logic w_fma_we;
    logic w_div_we;
    logic w_cmp_we;
    logic w_div_hit;
    logic w_cmp_hit;
    logic w_err_set;

    assign alloc_ready_o = (r_count != 6'(DEPTH));
    assign alloc_tag_o   = r_tail;
    assign out_valid_o   = (r_state[r_head] == SLOT_DONE);
    assign out_tag_o     = r_head;
    assign out_result_o  = r_result[r_head];
    assign out_status_o  = r_status[r_head];
    assign count_o       = r_count;
    assign err_o         = r_err;

    assign w_alloc  = alloc_valid_i && alloc_ready_o;
    assign w_retire = out_valid_o && out_ready_i;

    // Same-tag collisions resolve fma > div > cmp; the losers are dropped.
    assign w_div_hit = fma_valid_i && (fma_tag_i == div_tag_i);
    assign w_cmp_hit = (fma_valid_i && (fma_tag_i == cmp_tag_i)) ||
                       (div_valid_i && (div_tag_i == cmp_tag_i));

    assign w_fma_we = fma_valid_i && (r_state[fma_tag_i] == SLOT_PEND);
    assign w_div_we = div_valid_i && !w_div_hit && (r_state[div_tag_i] == SLOT_PEND);
    assign w_cmp_we = cmp_valid_i && !w_cmp_hit && (r_state[cmp_tag_i] == SLOT_PEND);

    assign w_err_set = (fma_valid_i && !w_fma_we) ||
                       (div_valid_i && !w_div_we) ||
                       (cmp_valid_i && !w_cmp_we);

    // Alloc, retire and write-back targets never coincide: alloc hits a FREE
    // slot, retire a DONE slot, and write-back only lands on PEND slots.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_state[i]  <= SLOT_FREE;
                r_result[i] <= '0;
                r_status[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_state[r_tail] <= SLOT_PEND;
            end
            if (w_retire) begin
                r_state[r_head] <= SLOT_FREE;
            end
            if (w_fma_we) begin
                r_state[fma_tag_i]  <= SLOT_DONE;
                r_result[fma_tag_i] <= fma_result_i;
                r_status[fma_tag_i] <= fma_status_i;
            end
            if (w_div_we) begin
                r_state[div_tag_i]  <= SLOT_DONE;
                r_result[div_tag_i] <= div_result_i;
                r_status[div_tag_i] <= div_status_i;
            end
            if (w_cmp_we) begin
                r_state[cmp_tag_i]  <= SLOT_DONE;
                r_result[cmp_tag_i] <= cmp_result_i;
                r_status[cmp_tag_i] <= cmp_status_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + tag_t'(1);
            end
            if (w_retire) begin
                r_head <= r_head + tag_t'(1);
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + 6'd1;
                2'b01:   r_count <= r_count - 6'd1;
                default: r_count <= r_count;
            endcase
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_plane_ray_rob.sv
// Self-checking bench for plane_ray_rob: directed scenarios plus a randomized
// run, all checked against an in-order queue model of the collector.
module tb_plane_ray_rob;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [4:0]  alloc_tag;
    logic        fma_valid = 1'b0;
    logic [4:0]  fma_tag = '0;
    logic [31:0] fma_result = '0;
    logic [4:0]  fma_status = '0;
    logic        div_valid = 1'b0;
    logic [4:0]  div_tag = '0;
    logic [31:0] div_result = '0;
    logic [4:0]  div_status = '0;
    logic        cmp_valid = 1'b0;
    logic [4:0]  cmp_tag = '0;
    logic [31:0] cmp_result = '0;
    logic [4:0]  cmp_status = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_tag;
    logic [31:0] out_result;
    logic [4:0]  out_status;
    logic [5:0]  count;
    logic        err;

    int nCmp  = 0;
    int nFail = 0;

    // Reference model: queue of outstanding tags in allocation order.
    int          q[$];
    bit          mDone[32];
    logic [31:0] mRes[32];
    logic [4:0]  mSt[32];
    bit          mErr;
    int          mTail;
    bit [31:0]   mClaimed;

    bit dueV[3][512];
    int dueTag[3][512];

    plane_ray_rob dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_tag_o(alloc_tag),
        .fma_valid_i(fma_valid), .fma_tag_i(fma_tag), .fma_result_i(fma_result), .fma_status_i(fma_status),
        .div_valid_i(div_valid), .div_tag_i(div_tag), .div_result_i(div_result), .div_status_i(div_status),
        .cmp_valid_i(cmp_valid), .cmp_tag_i(cmp_tag), .cmp_result_i(cmp_result), .cmp_status_i(cmp_status),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_tag_o(out_tag),
        .out_result_o(out_result), .out_status_o(out_status),
        .count_o(count), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic bit isPending(input int t);
        foreach (q[i]) if (q[i] == t) return !mDone[t];
        return 1'b0;
    endfunction

    task automatic modelWrite(input bit v, input logic [4:0] t, input logic [31:0] r, input logic [4:0] s);
        if (v) begin
            if (mClaimed[t]) begin
                mErr = 1'b1;
            end else begin
                mClaimed[t] = 1'b1;
                if (isPending(int'(t))) begin
                    mDone[t] = 1'b1;
                    mRes[t]  = r;
                    mSt[t]   = s;
                end else begin
                    mErr = 1'b1;
                end
            end
        end
    endtask

    // Advances the model by the current inputs, then crosses one clock edge.
    task automatic step();
        bit expValid;
        bit allocOk;
        expValid = (q.size() > 0) && mDone[q[0]];
        allocOk  = (q.size() < 32);
        mClaimed = '0;
        modelWrite(fma_valid, fma_tag, fma_result, fma_status);
        modelWrite(div_valid, div_tag, div_result, div_status);
        modelWrite(cmp_valid, cmp_tag, cmp_result, cmp_status);
        if (expValid && out_ready) void'(q.pop_front());
        if (alloc_valid && allocOk) begin
            q.push_back(mTail);
            mDone[mTail] = 1'b0;
            mTail = (mTail + 1) % 32;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        fma_valid   = 1'b0;
        div_valid   = 1'b0;
        cmp_valid   = 1'b0;
        out_ready   = 1'b0;
    endtask

    task automatic modelClear();
        q.delete();
        foreach (mDone[i]) mDone[i] = 1'b0;
        mErr  = 1'b0;
        mTail = 0;
    endtask

    task automatic applyReset();
        idle();
        rst = 1'b1;
        modelClear();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        nCmp += 6;
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (alloc_ready !== 1'b1) begin nFail++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
        if (alloc_tag !== 5'd0) begin nFail++; $display("FAIL reset_alloc_tag: got %0d expected 0", alloc_tag); end
        if (count !== 6'd0) begin nFail++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (err !== 1'b0) begin nFail++; $display("FAIL reset_err: got %b expected 0", err); end
        if (out_result !== 32'h0 || out_status !== 5'h0) begin
            nFail++; $display("FAIL reset_out_data: got %h/%h expected 0/0", out_result, out_status);
        end
    endtask

    task automatic test_inorder();
        bit expV;
        int expT;
        applyReset();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            alloc_valid = (c < 3);
            cmp_valid = (c == 3); cmp_tag = 5'd2; cmp_result = 32'hC0000002; cmp_status = 5'h02;
            fma_valid = (c == 4); fma_tag = 5'd0; fma_result = 32'hA0000000; fma_status = 5'h10;
            div_valid = (c == 6); div_tag = 5'd1; div_result = 32'hB0000001; div_status = 5'h01;
            expV = (c == 5) || (c == 7) || (c == 8);
            expT = (c == 5) ? 0 : (c == 7) ? 1 : 2;
            nCmp++;
            if (out_valid !== expV) begin nFail++; $display("FAIL inorder_valid c%0d: got %b expected %b", c, out_valid, expV); end
            if (expV) begin
                nCmp += 2;
                if (out_tag !== 5'(expT)) begin nFail++; $display("FAIL inorder_tag c%0d: got %0d expected %0d", c, out_tag, expT); end
                if (out_result !== mRes[expT]) begin nFail++; $display("FAIL inorder_result c%0d: got %h expected %h", c, out_result, mRes[expT]); end
            end
            step();
        end
        idle();
        nCmp += 2;
        if (count !== 6'd0) begin nFail++; $display("FAIL inorder_count: got %0d expected 0", count); end
        if (err !== 1'b0) begin nFail++; $display("FAIL inorder_err: got %b expected 0", err); end
    endtask

    task automatic test_full();
        applyReset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 33; i++) step();
        nCmp += 3;
        if (alloc_ready !== 1'b0) begin nFail++; $display("FAIL full_ready: got %b expected 0", alloc_ready); end
        if (count !== 6'd32) begin nFail++; $display("FAIL full_count: got %0d expected 32", count); end
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL full_valid: got %b expected 0", out_valid); end
        alloc_valid = 1'b0;
        fma_valid = 1'b1; fma_tag = 5'd0; fma_result = 32'h12345678; fma_status = 5'h03;
        step();
        fma_valid = 1'b0;
        nCmp += 2;
        if (out_valid !== 1'b1) begin nFail++; $display("FAIL full_head_valid: got %b expected 1", out_valid); end
        if (alloc_ready !== 1'b0) begin nFail++; $display("FAIL full_ready_before_retire: got %b expected 0", alloc_ready); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        nCmp += 3;
        if (alloc_ready !== 1'b1) begin nFail++; $display("FAIL full_reraise: got %b expected 1", alloc_ready); end
        if (count !== 6'd31) begin nFail++; $display("FAIL full_count_after_retire: got %0d expected 31", count); end
        if (alloc_tag !== 5'd0) begin nFail++; $display("FAIL full_wrap_tag: got %0d expected 0", alloc_tag); end
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        nCmp += 2;
        if (count !== 6'd32) begin nFail++; $display("FAIL full_realloc_count: got %0d expected 32", count); end
        if (count !== 6'(q.size())) begin nFail++; $display("FAIL full_model_count: got %0d expected %0d", count, q.size()); end
    endtask

    task automatic test_stall();
        applyReset();
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        fma_valid = 1'b1; fma_tag = 5'd0; fma_result = 32'h3F800000; fma_status = 5'h00;
        step();
        fma_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nCmp += 2;
            if (out_valid !== 1'b1) begin nFail++; $display("FAIL stall_valid %0d: got %b expected 1", i, out_valid); end
            if (out_result !== 32'h3F800000) begin nFail++; $display("FAIL stall_result %0d: got %h expected 3f800000", i, out_result); end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        nCmp += 3;
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL stall_after_valid: got %b expected 0", out_valid); end
        if (count !== 6'd0) begin nFail++; $display("FAIL stall_count: got %0d expected 0", count); end
        if (alloc_tag !== 5'd1) begin nFail++; $display("FAIL stall_tail: got %0d expected 1", alloc_tag); end
    endtask

    task automatic test_collision();
        applyReset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        alloc_valid = 1'b0;
        fma_valid = 1'b1; fma_tag = 5'd4; fma_result = 32'hAAAA0004; fma_status = 5'h11;
        div_valid = 1'b1; div_tag = 5'd4; div_result = 32'hBBBB0004; div_status = 5'h0B;
        step();
        fma_valid = 1'b0; div_valid = 1'b0;
        nCmp++;
        if (err !== 1'b1) begin nFail++; $display("FAIL collide_err: got %b expected 1", err); end
        for (int t = 0; t < 4; t++) begin
            cmp_valid = 1'b1; cmp_tag = 5'(t); cmp_result = 32'h100 + 32'(t); cmp_status = 5'(t);
            step();
        end
        cmp_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            nCmp += 3;
            if (out_valid !== 1'b1) begin nFail++; $display("FAIL collide_valid t%0d: got %b expected 1", t, out_valid); end
            if (out_tag !== 5'(t)) begin nFail++; $display("FAIL collide_tag: got %0d expected %0d", out_tag, t); end
            if (out_result !== mRes[t]) begin nFail++; $display("FAIL collide_result t%0d: got %h expected %h", t, out_result, mRes[t]); end
            step();
        end
        out_ready = 1'b0;
        cmp_valid = 1'b1; cmp_tag = 5'd10; cmp_result = 32'h0; cmp_status = 5'h0;
        step();
        cmp_valid = 1'b0;
        nCmp += 2;
        if (err !== 1'b1) begin nFail++; $display("FAIL free_write_err: got %b expected 1", err); end
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL free_write_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        int nAlloc;
        int nRetired;
        int retireExp;
        int p;
        int lat;
        int c2;
        int cyc;
        applyReset();
        foreach (dueV[a, b]) dueV[a][b] = 1'b0;
        nAlloc = 0; nRetired = 0; retireExp = 0;
        cyc = 0;
        while (cyc < 400 && (cyc < 100 || q.size() > 0)) begin
            alloc_valid = (cyc < 100) && ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            fma_valid = dueV[0][cyc]; fma_tag = 5'(dueTag[0][cyc]); fma_result = $urandom; fma_status = 5'($urandom);
            div_valid = dueV[1][cyc]; div_tag = 5'(dueTag[1][cyc]); div_result = $urandom; div_status = 5'($urandom);
            cmp_valid = dueV[2][cyc]; cmp_tag = 5'(dueTag[2][cyc]); cmp_result = $urandom; cmp_status = 5'($urandom);
            nCmp += 4;
            if (count !== 6'(q.size())) begin nFail++; $display("FAIL rand_count cyc%0d: got %0d expected %0d", cyc, count, q.size()); end
            if (alloc_ready !== (q.size() < 32)) begin nFail++; $display("FAIL rand_ready cyc%0d: got %b", cyc, alloc_ready); end
            if (alloc_tag !== 5'(mTail)) begin nFail++; $display("FAIL rand_alloc_tag cyc%0d: got %0d expected %0d", cyc, alloc_tag, mTail); end
            if (out_valid !== ((q.size() > 0) && mDone[q[0]])) begin
                nFail++; $display("FAIL rand_valid cyc%0d: got %b", cyc, out_valid);
            end
            if (q.size() > 0 && mDone[q[0]]) begin
                nCmp += 2;
                if (out_tag !== 5'(retireExp)) begin nFail++; $display("FAIL rand_order cyc%0d: got %0d expected %0d", cyc, out_tag, retireExp); end
                if (out_result !== mRes[q[0]] || out_status !== mSt[q[0]]) begin
                    nFail++; $display("FAIL rand_data cyc%0d: got %h/%h expected %h/%h", cyc, out_result, out_status, mRes[q[0]], mSt[q[0]]);
                end
                if (out_ready) begin
                    nRetired++;
                    retireExp = (retireExp + 1) % 32;
                end
            end
            if (alloc_valid && q.size() < 32) begin
                p   = $urandom_range(0, 2);
                lat = (p == 0) ? 2 : (p == 1) ? 4 : 1;
                c2  = cyc + lat;
                while (c2 < 511 && dueV[p][c2]) c2++;
                dueV[p][c2]   = 1'b1;
                dueTag[p][c2] = mTail;
                nAlloc++;
            end
            step();
            cyc++;
        end
        idle();
        nCmp += 3;
        if (nRetired !== nAlloc) begin nFail++; $display("FAIL rand_drops: got %0d retired expected %0d", nRetired, nAlloc); end
        if (count !== 6'd0) begin nFail++; $display("FAIL rand_drain_count: got %0d expected 0", count); end
        if (err !== 1'b0) begin nFail++; $display("FAIL rand_err: got %b expected 0", err); end
    endtask

    task automatic test_reset_mid();
        applyReset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        alloc_valid = 1'b0;
        fma_valid = 1'b1; fma_tag = 5'd20; fma_result = 32'h0; fma_status = 5'h0;
        step();
        fma_valid = 1'b0;
        nCmp++;
        if (err !== 1'b1) begin nFail++; $display("FAIL mid_pre_err: got %b expected 1", err); end
        rst = 1'b1;
        modelClear();
        #1;
        nCmp += 4;
        if (count !== 6'd0) begin nFail++; $display("FAIL mid_count: got %0d expected 0", count); end
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        if (err !== 1'b0) begin nFail++; $display("FAIL mid_err: got %b expected 0", err); end
        if (alloc_tag !== 5'd0) begin nFail++; $display("FAIL mid_tag: got %0d expected 0", alloc_tag); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_valid = 1'b1; cmp_tag = 5'd3; cmp_result = 32'hDEAD0003; cmp_status = 5'h1F;
        step();
        cmp_valid = 1'b0;
        nCmp += 3;
        if (err !== 1'b1) begin nFail++; $display("FAIL stale_err: got %b expected 1", err); end
        if (out_valid !== 1'b0) begin nFail++; $display("FAIL stale_valid: got %b expected 0", out_valid); end
        if (count !== 6'd0) begin nFail++; $display("FAIL stale_count: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_inorder();
        test_full();
        test_stall();
        test_collision();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
